tx_frame_sequencer: RTL and testbench

//  Frame-level controller in front of the Pack -> Spread -> QPSK -> FIR transmit chain.
//  - On i_start, emits one frame as a byte stream into Pack: preamble, length byte, i_len payload bytes, optional CRC.
//  - Then idles the chain for a fixed drain period so Spread/QPSK/FIR flush before the next frame.
//  - Owns all sequencing of Pack's byte input; upstream payload source is throttled through s_ready.

---
 rtl/tx_frame_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: frame-level byte sequencer in front of the Pack stage.
// Emits preamble, length byte, payload pass-through and an optional CRC-8, then
// idles the transmit chain for DRAIN_CYCLES cycles so downstream stages flush.
// Optional feature macro: TX_SEQ_CRC8_EN (CRC-8 poly 0x07, init 0, MSB first).
// Ports:
//   i_clk, i_reset          clock, asynchronous active-low reset
//   i_start, i_len, i_abort frame request, payload length, abort
//   s_data/s_valid/s_last   payload source, throttled by s_ready
//   o_bits/o_valid/i_ready  byte stream towards Pack
//   o_busy, o_done, o_len_err status (done/len_err are 1-cycle pulses)
module tx_frame_sequencer #(
   parameter int unsigned                SIZE_INPUT_BIT = 8,
   parameter int unsigned                PREAMBLE_LEN   = 4,
   parameter logic [SIZE_INPUT_BIT-1:0]  PREAMBLE_BYTE  = 8'hAA,
   parameter int unsigned                DRAIN_CYCLES   = 64
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic [7:0]                i_len,
   input  logic                      i_abort,
   input  logic [SIZE_INPUT_BIT-1:0] s_data,
   input  logic                      s_valid,
   input  logic                      s_last,
   output logic                      s_ready,
   output logic [SIZE_INPUT_BIT-1:0] o_bits,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_len_err
);

   localparam int unsigned DW  = SIZE_INPUT_BIT;
   localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [7:0]     PRE_LAST   = 8'(PREAMBLE_LEN - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_LENGTH   = 3'd2,
      ST_PAYLOAD  = 3'd3,
`ifdef TX_SEQ_CRC8_EN
      ST_CRC      = 3'd4,
`endif
      ST_DRAIN    = 3'd5
   } state_t;

   // State entered after the last length/payload byte
`ifdef TX_SEQ_CRC8_EN
   localparam state_t ST_TAIL = ST_CRC;
`else
   localparam state_t ST_TAIL = ST_DRAIN;
`endif

   state_t         state_q, state_d;
   logic [7:0]     len_q, len_d;
   logic [7:0]     byte_cnt_q, byte_cnt_d;
   logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
   logic           done_q, done_d;
   logic           len_err_q, len_err_d;
   logic           accept_c;
   logic           last_byte_c;
`ifdef TX_SEQ_CRC8_EN
   logic [7:0]     crc_q, crc_d;

   // One byte of CRC-8, poly 0x07, MSB first
   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction
`endif

   assign accept_c    = o_valid & i_ready;
   assign last_byte_c = (byte_cnt_q == (len_q - 8'd1));

   // State and counter registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         byte_cnt_q  <= '0;
         drain_cnt_q <= '0;
         done_q      <= 1'b0;
         len_err_q   <= 1'b0;
`ifdef TX_SEQ_CRC8_EN
         crc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         byte_cnt_q  <= byte_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         done_q      <= done_d;
         len_err_q   <= len_err_d;
`ifdef TX_SEQ_CRC8_EN
         crc_q       <= crc_d;
`endif
      end
   end

   // Next-state, counters and status pulses
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      byte_cnt_d  = byte_cnt_q;
      drain_cnt_d = drain_cnt_q;
      len_err_d   = 1'b0;
`ifdef TX_SEQ_CRC8_EN
      crc_d       = crc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               len_d      = i_len;
               byte_cnt_d = '0;
`ifdef TX_SEQ_CRC8_EN
               crc_d      = '0;
`endif
               state_d    = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            if (i_abort) begin
               state_d = ST_DRAIN;
            end else if (accept_c) begin
               if (byte_cnt_q == PRE_LAST) begin
                  byte_cnt_d = '0;
                  state_d    = ST_LENGTH;
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
         ST_LENGTH: begin
            if (i_abort) begin
               state_d = ST_DRAIN;
            end else if (accept_c) begin
`ifdef TX_SEQ_CRC8_EN
               crc_d   = crc8_upd(crc_q, len_q);
`endif
               state_d = (len_q != 8'd0) ? ST_PAYLOAD : ST_TAIL;
            end
         end
         ST_PAYLOAD: begin
            if (i_abort) begin
               state_d = ST_DRAIN;
            end else if (accept_c) begin
`ifdef TX_SEQ_CRC8_EN
               crc_d     = crc8_upd(crc_q, 8'(s_data));
`endif
               // s_last must coincide exactly with the len-th byte
               len_err_d = (s_last != last_byte_c);
               if (last_byte_c) begin
                  state_d = ST_TAIL;
               end else begin
                  byte_cnt_d = byte_cnt_q + 8'd1;
               end
            end
         end
`ifdef TX_SEQ_CRC8_EN
         ST_CRC: begin
            if (i_abort || accept_c) begin
               state_d = ST_DRAIN;
            end
         end
`endif
         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = ST_IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + DCW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) begin
         drain_cnt_d = '0;
      end
      // o_done is high during the final DRAIN cycle
      done_d = (state_d == ST_DRAIN) && (drain_cnt_d == DRAIN_LAST);
   end

   // Outputs decoded from state; payload is a zero-latency pass-through
   always_comb begin
      o_bits  = '0;
      o_valid = 1'b0;
      s_ready = 1'b0;
      o_busy  = (state_q != ST_IDLE);
      case (state_q)
         ST_PREAMBLE: begin
            o_valid = 1'b1;
            o_bits  = PREAMBLE_BYTE;
         end
         ST_LENGTH: begin
            o_valid = 1'b1;
            o_bits  = DW'(len_q);
         end
         ST_PAYLOAD: begin
            o_valid = s_valid;
            o_bits  = s_data;
            s_ready = i_ready;
         end
`ifdef TX_SEQ_CRC8_EN
         ST_CRC: begin
            o_valid = 1'b1;
            o_bits  = DW'(crc_q);
         end
`endif
         default: ;
      endcase
   end

   assign o_done    = done_q;
   assign o_len_err = len_err_q;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// tb_tx_frame_sequencer: randomized bench for tx_frame_sequencer. A frame is
// modelled as the expected byte list {preamble, length, payload, [crc]}; each
// transfer is checked against the list, followed by the drain/done timing.
module tb_tx_frame_sequencer;

   localparam int unsigned PRE_LEN  = 4;
   localparam int unsigned DRAIN    = 64;
   localparam logic [7:0]  PRE_BYTE = 8'hAA;

   logic       i_clk   = 1'b0;
   logic       i_reset = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_len   = 8'd0;
   logic       i_abort = 1'b0;
   logic [7:0] s_data  = 8'd0;
   logic       s_valid = 1'b0;
   logic       s_last  = 1'b0;
   logic       s_ready;
   logic [7:0] o_bits;
   logic       o_valid;
   logic       i_ready = 1'b0;
   logic       o_busy;
   logic       o_done;
   logic       o_len_err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] pay_r [256];

   tx_frame_sequencer #(
      .SIZE_INPUT_BIT (8),
      .PREAMBLE_LEN   (PRE_LEN),
      .PREAMBLE_BYTE  (PRE_BYTE),
      .DRAIN_CYCLES   (DRAIN)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (i_start),
      .i_len     (i_len),
      .i_abort   (i_abort),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .o_bits    (o_bits),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_len_err (o_len_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // CRC-8 (poly 0x07) over the length byte and the first n payload bytes
   function automatic logic [7:0] ref_crc(input logic [7:0] len, input int n);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'd0;
      for (int i = -1; i < n; i++) begin
         b = (i < 0) ? len : pay_r[i];
         c = c ^ b;
         for (int j = 0; j < 8; j++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_sready"}, 32'(s_ready), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_done"}, 32'(o_done), 32'd0);
      check({tag, "_lenerr"}, 32'(o_len_err), 32'd0);
      check({tag, "_bits"}, 32'(o_bits), 32'd0);
   endtask

   // mode: 0 ready always, 1 ready toggling, 2 random ready/valid.
   // abort_k/reset_k: transfer index at which to abort/reset (-1 = never).
   task automatic run_frame(input int len, input int mode, input int last_pos,
                            input int abort_k, input int reset_k);
      logic [7:0] exp_q[$];
      int  k, pidx, total, cyc;
      bit  err_next, finished, in_pay, exp_valid;
      exp_q = {};
      for (int i = 0; i < int'(PRE_LEN); i++) exp_q.push_back(PRE_BYTE);
      exp_q.push_back(8'(len));
      for (int i = 0; i < len; i++) exp_q.push_back(pay_r[i]);
`ifdef TX_SEQ_CRC8_EN
      exp_q.push_back(ref_crc(8'(len), len));
`endif
      total = exp_q.size();

      @(negedge i_clk);
      i_start = 1'b1; i_len = 8'(len); i_abort = 1'b0; s_valid = 1'b0;
      #1;
      check("idle_busy", 32'(o_busy), 32'd0);
      check("idle_valid", 32'(o_valid), 32'd0);

      k = 0; pidx = 0; err_next = 1'b0; finished = 1'b0;
      for (cyc = 0; cyc < 3000 && !finished; cyc++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         in_pay  = (k > int'(PRE_LEN)) && (k <= int'(PRE_LEN) + len);
         case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ((cyc % 2) == 0);
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
         if (in_pay) s_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
         else        s_valid = 1'($urandom_range(0, 1));
         s_data = (pidx < len) ? pay_r[pidx] : 8'($urandom);
         s_last = (pidx == last_pos);
         if (k == reset_k) begin
            i_ready = 1'b1; s_valid = 1'b1;
            #2 i_reset = 1'b0;
            #1 check_reset_outputs("midreset");
            @(negedge i_clk);
            i_reset = 1'b1;
            return;
         end
         if (k == abort_k) begin
            i_abort = 1'b1; i_ready = 1'b0; s_valid = 1'b0;
         end
         #1;
         check("len_err", 32'(o_len_err), 32'(err_next));
         err_next = 1'b0;
         check("busy", 32'(o_busy), 32'd1);
         exp_valid = in_pay ? s_valid : 1'b1;
         check("o_valid", 32'(o_valid), 32'(exp_valid));
         check("s_ready", 32'(s_ready), in_pay ? 32'(i_ready) : 32'd0);
         if (exp_valid) check("o_bits", 32'(o_bits), 32'(exp_q[0]));
         if (k == abort_k) begin
            finished = 1'b1;
         end else if (exp_valid && i_ready) begin
            void'(exp_q.pop_front());
            if (in_pay) begin
               err_next = (s_last != (pidx == len - 1));
               pidx++;
            end
            k++;
            if (k == total) finished = 1'b1;
         end
      end
      if (!finished) begin
         check("timeout", 32'(k), 32'(total));
         return;
      end

      // Drain: idle output, start requests ignored, done on the last cycle
      for (int n = 1; n <= int'(DRAIN) + 2; n++) begin
         @(negedge i_clk);
         i_abort = 1'b0;
         i_ready = 1'($urandom_range(0, 1));
         s_valid = 1'($urandom_range(0, 1));
         s_last  = 1'($urandom_range(0, 1));
         i_start = (n == 10) || (n == int'(DRAIN));
         #1;
         check("len_err", 32'(o_len_err), 32'(err_next));
         err_next = 1'b0;
         check("drain_valid", 32'(o_valid), 32'd0);
         check("drain_sready", 32'(s_ready), 32'd0);
         check("done", 32'(o_done), 32'(n == int'(DRAIN)));
         check("drain_busy", 32'(o_busy), 32'(n <= int'(DRAIN)));
      end
      i_start = 1'b0;
   endtask

   task automatic fill_random(input int len);
      for (int i = 0; i < len; i++) pay_r[i] = 8'($urandom);
   endtask

   initial begin
      int len, lp;
      #12;
      check_reset_outputs("reset");
      @(negedge i_clk);
      i_reset = 1'b1;

      // Directed frames
      pay_r[0] = 8'h11; pay_r[1] = 8'h22; pay_r[2] = 8'h33;
      run_frame(3, 0, 2, -1, -1);
      run_frame(3, 1, 2, -1, -1);
      pay_r[0] = 8'h00;
      run_frame(1, 0, 0, -1, -1);
      run_frame(0, 0, -1, -1, -1);
      fill_random(4);
      run_frame(4, 2, 1, -1, -1);
      fill_random(5);
      run_frame(5, 0, 4, int'(PRE_LEN) + 3, -1);
      run_frame(2, 1, 1, 2, -1);

      // Reset in the middle of the payload, then a clean frame
      fill_random(6);
      run_frame(6, 0, 5, -1, int'(PRE_LEN) + 3);
      @(negedge i_clk);
      #1 check("post_reset_busy", 32'(o_busy), 32'd0);
      fill_random(3);
      run_frame(3, 2, 2, -1, -1);

      // Randomized frames, including the maximum length
      for (int f = 0; f < 8; f++) begin
         len = $urandom_range(0, 24);
         lp  = ($urandom_range(0, 1) != 0) ? len - 1 : int'($urandom_range(0, 24));
         fill_random(len);
         run_frame(len, int'($urandom_range(0, 2)), lp, -1, -1);
      end
      fill_random(255);
      run_frame(255, 0, 254, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
